// File: rtl/sap_ram_pkg.sv
// Shared types and defaults for the SAP RAM arbiter slice.
package sap_ram_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, RD, RESP, WR} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;
endpackage

// File: rtl/sap_rr_pick2.sv
// Two-input round-robin picker: on a tie the requester not granted last wins.
module sap_rr_pick2
  import sap_ram_pkg::*;
(
  input  logic   i_req_cpu,
  input  logic   i_req_ldr,
  input  owner_t i_last,
  output logic   o_gnt_cpu,
  output logic   o_gnt_ldr,
  output owner_t o_last
);
  assign o_gnt_cpu = i_req_cpu & (~i_req_ldr | (i_last == OWN_LDR));
  assign o_gnt_ldr = i_req_ldr & ~o_gnt_cpu;

  always_comb begin
    o_last = i_last;
    if (o_gnt_cpu)      o_last = OWN_CPU;
    else if (o_gnt_ldr) o_last = OWN_LDR;
  end
endmodule

// File: rtl/sap_ram_arbiter.sv
// Shares the SAP RAM between CPU reads and an external loader, one transaction at a time.
// Optional write protection of addresses >= PROT_BASE: define RAM_ARB_WRPROT_EN.
module sap_ram_arbiter
  import sap_ram_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  PROT_BASE = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ldr_valid,
  input  logic              ldr_write,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ready,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic              ldr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            r_state, w_state_nxt;
  owner_t            r_own, r_last, w_last_nxt;
  logic              r_prot;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_cpu_rdata, r_ldr_rdata;
  logic              r_mem_we, r_cpu_rvalid, r_ldr_rvalid, r_ldr_err;
  logic              w_idle, w_cpu_m, w_ldr_m, w_gnt_cpu, w_gnt_ldr, w_prot_hit;

`ifdef RAM_ARB_WRPROT_EN
  assign w_prot_hit = (ldr_addr >= PROT_BASE);
`else
  logic w_unused_prot;
  assign w_unused_prot = ^PROT_BASE;
  assign w_prot_hit    = 1'b0;
`endif

  // Masking by the owner's own return pulse keeps a held request from being re-granted.
  assign w_idle  = (r_state == IDLE) & ~clr;
  assign w_cpu_m = w_idle & cpu_req & ~r_cpu_rvalid;
  assign w_ldr_m = w_idle & ldr_valid & ~r_ldr_rvalid & ~r_ldr_err;

  sap_rr_pick2 u_pick (
    .i_req_cpu (w_cpu_m),
    .i_req_ldr (w_ldr_m),
    .i_last    (r_last),
    .o_gnt_cpu (w_gnt_cpu),
    .o_gnt_ldr (w_gnt_ldr),
    .o_last    (w_last_nxt)
  );

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ldr_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_ldr) begin
          ldr_ready   = 1'b1;
          w_state_nxt = ldr_write ? WR : RD;
        end else if (w_gnt_cpu) begin
          w_state_nxt = RD;
        end
      end
      RD:      w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      WR:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_last       <= OWN_LDR;
      r_own        <= OWN_CPU;
      r_prot       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_ldr_err    <= 1'b0;
    end else begin
      r_last       <= w_last_nxt;
      r_mem_we     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_ldr_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_ldr) begin
            r_own      <= OWN_LDR;
            r_mem_addr <= ldr_addr;
            if (ldr_write) begin
              r_mem_wdata <= ldr_wdata;
              r_mem_we    <= ~w_prot_hit;
              r_prot      <= w_prot_hit;
            end
          end else if (w_gnt_cpu) begin
            r_own      <= OWN_CPU;
            r_mem_addr <= cpu_addr;
          end
        end
        RESP: begin
          if (r_own == OWN_CPU) begin
            r_cpu_rdata  <= mem_rdata;
            r_cpu_rvalid <= 1'b1;
          end else begin
            r_ldr_rdata  <= mem_rdata;
            r_ldr_rvalid <= 1'b1;
          end
        end
        WR: begin
          r_ldr_err <= r_prot;
          r_prot    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_stall  = cpu_req & ~r_cpu_rvalid;
  assign ldr_rdata  = r_ldr_rdata;
  assign ldr_rvalid = r_ldr_rvalid;
  assign ldr_err    = r_ldr_err;
endmodule
